// File: rtl/cpu6502_pkg.sv
// Shared 6502 definitions: flag-instruction encoding, status bit positions, reset value.
package cpu6502_pkg;

  typedef enum logic [2:0] {
    FLAG_NOP = 3'd0,
    FLAG_CLC = 3'd1,
    FLAG_SEC = 3'd2,
    FLAG_CLI = 3'd3,
    FLAG_SEI = 3'd4,
    FLAG_CLD = 3'd5,
    FLAG_SED = 3'd6,
    FLAG_CLV = 3'd7
  } flag_op_t;

  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  // I set, every other stored flag clear
  localparam logic [7:0] RESET_P_DEFAULT = 8'h04;

  // alu_mask bit order is {N,V,Z,C}
  localparam int M_C = 0;
  localparam int M_Z = 1;
  localparam int M_V = 2;
  localparam int M_N = 3;

endpackage

// File: rtl/status_reg_6502.sv
// 6502 status register: ALU flags commit one RDY cycle after alu_upd; set/clear, PLP, BIT, IRQ apply same cycle.
// RDY low freezes every flop including the pending commit; outputs are combinational from the flags.
module status_reg_6502
  import cpu6502_pkg::*;
#(
  parameter logic [7:0] RESET_P = RESET_P_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RDY,
  input  logic       alu_upd,
  input  logic [3:0] alu_mask,
  input  logic       alu_CO,
  input  logic       alu_V,
  input  logic       alu_Z,
  input  logic       alu_N,
  input  logic [2:0] flag_op,
  input  logic       plp,
  input  logic       bit_op,
  input  logic [7:0] DI,
  input  logic       irq_ack,
  input  logic       brk,
  output logic [7:0] P,
  output logic [7:0] P_push,
  output logic       C_out,
  output logic       D_out
);

  logic       flag_n, flag_v, flag_d, flag_i, flag_z, flag_c;
  logic       pend_vld;
  logic [3:0] pend_mask;

  logic       n_nxt, v_nxt, d_nxt, i_nxt, z_nxt, c_nxt;
  logic       cmt_n, cmt_v, cmt_z, cmt_c;
  flag_op_t   fop;

  assign fop   = flag_op_t'(flag_op);
  assign cmt_n = pend_vld & pend_mask[M_N];
  assign cmt_v = pend_vld & pend_mask[M_V];
  assign cmt_z = pend_vld & pend_mask[M_Z];
  assign cmt_c = pend_vld & pend_mask[M_C];

  // Each flag resolves its sources independently: plp > irq_ack > flag_op > bit_op > ALU commit
  always_comb begin
    n_nxt = flag_n;
    v_nxt = flag_v;
    d_nxt = flag_d;
    i_nxt = flag_i;
    z_nxt = flag_z;
    c_nxt = flag_c;

    if (cmt_n) n_nxt = alu_N;
    if (cmt_v) v_nxt = alu_V;
    if (cmt_z) z_nxt = alu_Z;
    if (cmt_c) c_nxt = alu_CO;

    if (bit_op) begin
      n_nxt = DI[P_N];
      v_nxt = DI[P_V];
    end

    case (fop)
      FLAG_CLC: c_nxt = 1'b0;
      FLAG_SEC: c_nxt = 1'b1;
      FLAG_CLI: i_nxt = 1'b0;
      FLAG_SEI: i_nxt = 1'b1;
      FLAG_CLD: d_nxt = 1'b0;
      FLAG_SED: d_nxt = 1'b1;
      FLAG_CLV: v_nxt = 1'b0;
      default:  ;
    endcase

    if (irq_ack) i_nxt = 1'b1;

    if (plp) begin
      n_nxt = DI[P_N];
      v_nxt = DI[P_V];
      d_nxt = DI[P_D];
      i_nxt = DI[P_I];
      z_nxt = DI[P_Z];
      c_nxt = DI[P_C];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flag_n    <= RESET_P[P_N];
      flag_v    <= RESET_P[P_V];
      flag_d    <= RESET_P[P_D];
      flag_i    <= RESET_P[P_I];
      flag_z    <= RESET_P[P_Z];
      flag_c    <= RESET_P[P_C];
      pend_vld  <= 1'b0;
      pend_mask <= 4'b0000;
    end else if (RDY) begin
      flag_n    <= n_nxt;
      flag_v    <= v_nxt;
      flag_d    <= d_nxt;
      flag_i    <= i_nxt;
      flag_z    <= z_nxt;
      flag_c    <= c_nxt;
      pend_vld  <= alu_upd;
      pend_mask <= alu_mask;
    end
  end

  always_comb begin
    P      = 8'h00;
    P[P_N] = flag_n;
    P[P_V] = flag_v;
    P[P_U] = 1'b1;
    P[P_B] = 1'b1;
    P[P_D] = flag_d;
    P[P_I] = flag_i;
    P[P_Z] = flag_z;
    P[P_C] = flag_c;

    P_push      = P;
    P_push[P_B] = brk;
  end

  assign C_out = flag_c;
  assign D_out = flag_d;

  // PLP discards the B and unused bits of the pulled byte
  logic unused_di;
  assign unused_di = ^DI[P_U:P_B];

endmodule
